// File: rtl/echo_delay_ctrl_pkg.sv
// Shared constants and FSM encoding for the echo delay-line controller.
package echo_delay_ctrl_pkg;

  localparam int ECHO_DATA_W    = 10;
  localparam int ECHO_ADDR_W    = 13;
  localparam int ECHO_DELAY_RST = 4800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_CAP  = 2'd3
  } echo_state_e;

endpackage

// File: rtl/echo_delay_ctrl_if.sv
// Port bundle between the delay-line controller and the single-port sample RAM.
interface echo_delay_ctrl_if
  import echo_delay_ctrl_pkg::*;
#(
  parameter int DATA_W = ECHO_DATA_W,
  parameter int ADDR_W = ECHO_ADDR_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_wren,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wren,
    input  ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/echo_ptr_gen.sv
// Write pointer, fill counter and delay register with deferred delay loads; read address = wr_ptr - delay.
// Latency: loads apply on the next edge in IDLE, otherwise on the CAP edge; no backpressure.
module echo_ptr_gen
  import echo_delay_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ECHO_ADDR_W,
  parameter int DELAY_RST = ECHO_DELAY_RST
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              in_idle,
  input  logic              step,
  input  logic              delay_load,
  input  logic [ADDR_W-1:0] delay_len,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fill_active,
  output logic              load_apply
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] delay;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] pend_val;
  logic              pend_vld;
  logic [ADDR_W-1:0] len_clamped;
  logic [ADDR_W-1:0] apply_val;

  assign len_clamped = (delay_len == '0) ? ONE : delay_len;
  // A load seen in CAP is newer than anything pending, so it wins directly.
  assign load_apply  = (in_idle & delay_load) | (step & (pend_vld | delay_load));
  assign apply_val   = delay_load ? len_clamped : pend_val;
  assign rd_addr     = wr_ptr - delay;
  assign fill_active = (fill_cnt < delay);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      delay    <= ADDR_W'(DELAY_RST);
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      if (step) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (load_apply) begin
        delay    <= apply_val;
        fill_cnt <= '0;
      end else if (step && fill_active) begin
        fill_cnt <= fill_cnt + ONE;
      end
      if (step) begin
        pend_vld <= 1'b0;
      end else if (!in_idle && delay_load) begin
        pend_vld <= 1'b1;
        pend_val <= len_clamped;
      end
    end
  end

endmodule

// File: rtl/echo_delay_ctrl.sv
// Sequences an external single-port RAM as a circular echo delay line: read old, write new, emit delayed sample.
// Latency: echo_valid 3 cycles after sample_en; no backpressure, sample_en while busy is dropped and flags overrun.
module echo_delay_ctrl
  import echo_delay_ctrl_pkg::*;
#(
  parameter int DATA_W    = ECHO_DATA_W,
  parameter int ADDR_W    = ECHO_ADDR_W,
  parameter int DELAY_RST = ECHO_DELAY_RST
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] x_in,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              delay_load,
  echo_delay_ctrl_if.master ram,
  output logic [DATA_W-1:0] echo_out,
  output logic              echo_valid,
  output logic              filling,
  output logic              overrun
);

  echo_state_e       state;
  echo_state_e       state_nxt;
  logic [DATA_W-1:0] x_reg;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              fill_active;
  logic              load_apply;
  logic              in_idle;
  logic              step;

  assign in_idle = (state == ST_IDLE);
  assign step    = (state == ST_CAP);

  echo_ptr_gen #(
    .ADDR_W    (ADDR_W),
    .DELAY_RST (DELAY_RST)
  ) u_ptr_gen (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .in_idle     (in_idle),
    .step        (step),
    .delay_load  (delay_load),
    .delay_len   (delay_len),
    .wr_ptr      (wr_ptr),
    .rd_addr     (rd_addr),
    .fill_active (fill_active),
    .load_apply  (load_apply)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM strobes decode straight from the state register so reset kills a write at once.
  always_comb begin
    state_nxt     = state;
    ram.ram_addr  = '0;
    ram.ram_wren  = 1'b0;
    ram.ram_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (sample_en) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        ram.ram_addr = rd_addr;
        state_nxt    = ST_WR;
      end
      ST_WR: begin
        ram.ram_addr  = wr_ptr;
        ram.ram_wren  = 1'b1;
        ram.ram_wdata = x_reg;
        state_nxt     = ST_CAP;
      end
      ST_CAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      echo_out   <= '0;
      echo_valid <= 1'b0;
      filling    <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      echo_valid <= (state == ST_WR);
      if (in_idle && sample_en) begin
        x_reg <= x_in;
      end
      if (!in_idle && sample_en) begin
        overrun <= 1'b1;
      end
      // Mute until the line holds a full delay of fresh samples.
      if (state == ST_WR) begin
        filling  <= fill_active;
        echo_out <= fill_active ? '0 : ram.ram_rdata;
      end else if (load_apply) begin
        filling <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Randomized directed bench for echo_delay_ctrl against a sample-history reference model.
module tb_echo_delay_ctrl;

  localparam int DW    = 10;
  localparam int AW    = 4;
  localparam int DRST  = 5;
  localparam int DEPTH = 1 << AW;

  logic          sysclk     = 1'b0;
  logic          rst_n      = 1'b1;
  logic          sample_en  = 1'b0;
  logic          delay_load = 1'b0;
  logic [DW-1:0] x_in       = '0;
  logic [AW-1:0] delay_len  = '0;
  logic [DW-1:0] echo_out;
  logic          echo_valid;
  logic          filling;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  echo_delay_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

  echo_delay_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DELAY_RST (DRST)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .x_in       (x_in),
    .delay_len  (delay_len),
    .delay_load (delay_load),
    .ram        (ram_if),
    .echo_out   (echo_out),
    .echo_valid (echo_valid),
    .filling    (filling),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge sysclk) begin
    if (ram_if.ram_wren) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= mem[ram_if.ram_addr];
  end

  // Reference model: every accepted sample in order, plus samples seen since the last delay change.
  logic [DW-1:0] hist[$];
  int            m_delay;
  int            m_fill;

  function automatic int clampd(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_delay = DRST;
    m_fill  = 0;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic load_idle(input int v);
    delay_load = 1'b1;
    delay_len  = AW'(v);
    tick();
    delay_load = 1'b0;
    m_delay = clampd(v);
    m_fill  = 0;
    chk("load_filling", 32'(filling), 1);
  endtask

  // ld_mask: bit0 load with the sample in IDLE (ld_b), bit1 in RD (ld_a), bit2 in WR (ld_b), bit3 in CAP (ld_b).
  task automatic send(input logic [DW-1:0] x, input int gap, input logic [3:0] ld_mask,
                      input int ld_a, input int ld_b);
    int            n;
    logic [AW-1:0] rd_exp;
    logic [AW-1:0] wr_exp;
    logic [DW-1:0] echo_exp;
    logic          fill_exp;
    if (ld_mask[0]) begin
      m_delay = clampd(ld_b);
      m_fill  = 0;
    end
    n        = hist.size();
    wr_exp   = AW'(n);
    rd_exp   = AW'(n - m_delay);
    fill_exp = (m_fill < m_delay);
    echo_exp = '0;
    if (!fill_exp) echo_exp = hist[n - m_delay];

    sample_en  = 1'b1;
    x_in       = x;
    delay_load = ld_mask[0];
    delay_len  = AW'(ld_b);
    tick();
    sample_en  = 1'b0;
    delay_load = ld_mask[1];
    delay_len  = AW'(ld_a);
    chk("rd_wren", 32'(ram_if.ram_wren), 0);
    chk("rd_addr", 32'(ram_if.ram_addr), 32'(rd_exp));
    chk("rd_valid", 32'(echo_valid), 0);
    tick();
    delay_load = ld_mask[2];
    delay_len  = AW'(ld_b);
    chk("wr_wren", 32'(ram_if.ram_wren), 1);
    chk("wr_addr", 32'(ram_if.ram_addr), 32'(wr_exp));
    chk("wr_data", 32'(ram_if.ram_wdata), 32'(x));
    tick();
    delay_load = ld_mask[3];
    delay_len  = AW'(ld_b);
    chk("cap_valid", 32'(echo_valid), 1);
    chk("cap_wren", 32'(ram_if.ram_wren), 0);
    chk("echo_out", 32'(echo_out), 32'(echo_exp));
    chk("filling", 32'(filling), 32'(fill_exp));
    tick();
    delay_load = 1'b0;
    chk("idle_valid", 32'(echo_valid), 0);
    hist.push_back(x);
    m_fill++;
    if (ld_mask[3:1] != 3'b000) begin
      m_delay = clampd((ld_mask[3] | ld_mask[2]) ? ld_b : ld_a);
      m_fill  = 0;
      chk("pend_filling", 32'(filling), 1);
    end
    repeat (gap - 4) tick();
  endtask

  task automatic send_rand(input int count);
    for (int i = 0; i < count; i++) begin
      send(DW'($urandom_range(0, (1 << DW) - 1)), 4 + int'($urandom_range(0, 4)), 4'b0000, 0, 0);
    end
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] echo_exp;
    int            n;

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_echo_out", 32'(echo_out), 0);
    chk("rst_echo_valid", 32'(echo_valid), 0);
    chk("rst_wren", 32'(ram_if.ram_wren), 0);
    chk("rst_addr", 32'(ram_if.ram_addr), 0);
    chk("rst_wdata", 32'(ram_if.ram_wdata), 0);
    chk("rst_filling", 32'(filling), 1);
    chk("rst_overrun", 32'(overrun), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    send_rand(7);

    load_idle(4);
    for (int i = 1; i <= 10; i++) send(DW'(i), 8, 4'b0000, 0, 0);

    load_idle(3);
    send_rand(40);

    load_idle(2);
    send_rand(5);
    send(DW'($urandom_range(0, 1023)), 6, 4'b0100, 0, 6);
    send_rand(9);

    send(DW'($urandom_range(0, 1023)), 5, 4'b0001, 0, 3);
    send_rand(5);

    send(DW'($urandom_range(0, 1023)), 5, 4'b1010, 9, 5);
    send_rand(7);

    load_idle(0);
    send_rand(4);

    // Second strobe two cycles after the first must be dropped.
    a        = DW'($urandom_range(0, 1023));
    n        = hist.size();
    echo_exp = (m_fill < m_delay) ? '0 : hist[n - m_delay];
    sample_en = 1'b1;
    x_in      = a;
    tick();
    sample_en = 1'b0;
    tick();
    sample_en = 1'b1;
    x_in      = ~a;
    chk("ovr_wdata", 32'(ram_if.ram_wdata), 32'(a));
    tick();
    sample_en = 1'b0;
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_valid", 32'(echo_valid), 1);
    chk("ovr_echo", 32'(echo_out), 32'(echo_exp));
    tick();
    chk("ovr_idle_valid", 32'(echo_valid), 0);
    hist.push_back(a);
    m_fill++;
    send_rand(3);
    chk("ovr_sticky", 32'(overrun), 1);

    // Reset landing in WR must drop the write enable without a clock edge.
    sample_en = 1'b1;
    x_in      = DW'($urandom_range(0, 1023));
    tick();
    sample_en = 1'b0;
    tick();
    chk("pre_rst_wren", 32'(ram_if.ram_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren", 32'(ram_if.ram_wren), 0);
    chk("arst_addr", 32'(ram_if.ram_addr), 0);
    chk("arst_wdata", 32'(ram_if.ram_wdata), 0);
    chk("arst_echo_out", 32'(echo_out), 0);
    chk("arst_valid", 32'(echo_valid), 0);
    chk("arst_filling", 32'(filling), 1);
    chk("arst_overrun", 32'(overrun), 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    send_rand(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
